fetch_unit: RTL and testbench

Instruction fetch stage of the mini-MIPS core. It sits between the program counter register and the decode stage. It reads the current PC, issues a single-outstanding read to instruction memory, and presents the returned instruction to decode with a valid/ready handshake. It also generates `next_PC` for the PC register. The PC register loads every cycle with no enable, so this block holds `next_PC == pc` whenever fetch must stall. Branch/jump redirects from downstream flush the stage.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: mini-MIPS instruction fetch stage with single-outstanding imem read, redirect flush and timeout.
module fetch_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_target_i,
  input  logic        id_ready_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic        fetch_err_o
);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, ERR} state_t;
  localparam logic [15:0] TMAX = 16'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic        if_valid_q, if_valid_d, err_q;
  logic [31:0] if_instr_q, if_instr_d, if_pc_q, if_pc_d;
  logic [31:0] pend_instr_q, pend_instr_d, pend_pc_q, pend_pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic        slot_free;
  assign slot_free   = !if_valid_q || id_ready_i;
  assign imem_req_o  = state_q == REQ;
  assign imem_addr_o = pc_i;
  assign if_valid_o  = if_valid_q;
  assign if_instr_o  = if_instr_q;
  assign if_pc_o     = if_pc_q;
  assign fetch_err_o = err_q;
  always_comb begin
    state_d      = state_q;
    next_pc_o    = pc_i;
    cnt_d        = '0;
    if_valid_d   = if_valid_q && !id_ready_i;
    if_instr_d   = if_instr_q;
    if_pc_d      = if_pc_q;
    pend_instr_d = pend_instr_q;
    pend_pc_d    = pend_pc_q;
    if (state_q == ERR) begin
      if_valid_d = 1'b0;
    end else if (redirect_valid_i) begin
      if_valid_d = 1'b0;
      if (redirect_target_i[1:0] != 2'b00) begin
        state_d = ERR;
      end else begin
        next_pc_o = redirect_target_i;
        // a request still in flight must be swallowed before refetching
        state_d   = ((state_q == REQ || state_q == DRAIN) && !imem_rvalid_i) ? DRAIN : REQ;
        cnt_d     = (state_q == DRAIN && state_d == DRAIN) ? cnt_q + 16'd1 : '0;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ;
        REQ, DRAIN: begin
          if (imem_rvalid_i) begin
            if (state_q == DRAIN) begin
              state_d = REQ;
            end else if (slot_free) begin
              if_valid_d = 1'b1;
              if_instr_d = imem_rdata_i;
              if_pc_d    = pc_i;
              next_pc_o  = pc_i + 32'd4;
            end else begin
              pend_instr_d = imem_rdata_i;
              pend_pc_d    = pc_i;
              state_d      = HOLD;
            end
          end else if (cnt_q >= TMAX) begin
            state_d    = ERR;
            if_valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        HOLD: begin
          if (if_valid_q && id_ready_i) begin
            if_valid_d = 1'b1;
            if_instr_d = pend_instr_q;
            if_pc_d    = pend_pc_q;
            next_pc_o  = pc_i + 32'd4;
            state_d    = REQ;
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      err_q        <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      pend_instr_q <= '0;
      pend_pc_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= state_d == ERR;
      if_valid_q   <= if_valid_d;
      if_instr_q   <= if_instr_d;
      if_pc_q      <= if_pc_d;
      pend_instr_q <= pend_instr_d;
      pend_pc_q    <= pend_pc_d;
      cnt_q        <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a PC register and a fixed-latency memory model.
module tb_fetch_unit;
  localparam logic [31:0] K = 32'hA5A5A5A5;
  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] pc, next_pc, imem_addr, imem_rdata, redir_tgt, if_instr, if_pc;
  logic        imem_req, imem_rvalid, redir, id_ready, if_valid, fetch_err;
  logic        mem_en, busy;
  int          lat, mcnt, total, bad;
  logic [31:0] maddr;
  fetch_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .pc_i(pc), .next_pc_o(next_pc),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .redirect_valid_i(redir), .redirect_target_i(redir_tgt),
    .id_ready_i(id_ready), .if_valid_o(if_valid), .if_instr_o(if_instr),
    .if_pc_o(if_pc), .fetch_err_o(fetch_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk or posedge reset)
    if (reset) pc <= '0;
    else pc <= next_pc;
  // memory answers lat cycles after the request cycle, even if the request is later withdrawn
  assign imem_rvalid = mem_en && (busy ? (mcnt == lat) : (imem_req && lat == 0));
  assign imem_rdata  = (busy ? maddr : imem_addr) ^ K;
  always @(posedge clk or posedge reset)
    if (reset) begin
      busy <= 1'b0; mcnt <= 0; maddr <= '0;
    end else if (busy) begin
      if (imem_rvalid) busy <= 1'b0;
      else mcnt <= mcnt + 1;
    end else if (imem_req && !imem_rvalid) begin
      busy <= 1'b1; mcnt <= 1; maddr <= imem_addr;
    end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic nxt();
    @(posedge clk);
    #2;
  endtask
  task automatic do_reset(input logic rdy);
    reset = 1'b1; redir = 1'b0; redir_tgt = '0; id_ready = rdy;
    #1;
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_instr", if_instr, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_next_pc", next_pc, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("idle_req", imem_req, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    total = 0; bad = 0; mem_en = 1'b1; lat = 0;
    redir = 1'b0; redir_tgt = '0; id_ready = 1'b1;
    // zero-wait streaming, one instruction per cycle
    do_reset(1'b1);
    nxt();
    chk("zw_first_addr", imem_addr, 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("zw_valid", if_valid, 1);
      chk("zw_if_pc", if_pc, 32'(4 * k));
      chk("zw_instr", if_instr, 32'(4 * k) ^ K);
      chk("zw_pc", pc, 32'(4 * k + 4));
    end
    // three-cycle memory: one instruction every four cycles
    lat = 3;
    do_reset(1'b1);
    for (int c = 1; c <= 12; c++) begin
      nxt();
      chk("lat_valid", if_valid, (c >= 5 && c % 4 == 1) ? 1 : 0);
      chk("lat_pc", pc, 32'(4 * ((c - 1) / 4)));
      chk("lat_next_pc", next_pc, 32'(4 * ((c - 1) / 4) + ((c % 4 == 0) ? 4 : 0)));
    end
    // decode stalls while a second response arrives
    lat = 0;
    do_reset(1'b0);
    nxt();
    chk("hold_first_next", next_pc, 4);
    nxt();
    chk("hold_valid", if_valid, 1);
    chk("hold_if_pc0", if_pc, 0);
    chk("hold_enter_next", next_pc, 4);
    for (int c = 3; c <= 6; c++) begin
      nxt();
      chk("hold_no_req", imem_req, 0);
      chk("hold_instr_stable", if_instr, K);
      chk("hold_pc", pc, 4);
      chk("hold_next_pc", next_pc, 4);
    end
    nxt();
    id_ready = 1'b1;
    #1 chk("hold_release_next", next_pc, 8);
    nxt();
    chk("hold_buf_pc", if_pc, 4);
    chk("hold_buf_instr", if_instr, 32'h4 ^ K);
    chk("hold_resume_addr", imem_addr, 8);
    chk("hold_resume_req", imem_req, 1);
    nxt();
    chk("hold_after_pc", if_pc, 8);
    // redirect while the fetch at 0x8 is outstanding
    lat = 2;
    do_reset(1'b1);
    repeat (6) nxt();
    nxt();
    redir = 1'b1; redir_tgt = 32'h100;
    #1;
    chk("rd_req_addr", imem_addr, 8);
    chk("rd_next_pc", next_pc, 32'h100);
    nxt();
    redir = 1'b0;
    #1;
    chk("rd_drain_req", imem_req, 0);
    chk("rd_drain_valid", if_valid, 0);
    nxt();
    chk("rd_stale_req", imem_req, 0);
    chk("rd_stale_valid", if_valid, 0);
    nxt();
    chk("rd_new_req", imem_req, 1);
    chk("rd_new_addr", imem_addr, 32'h100);
    chk("rd_new_valid", if_valid, 0);
    repeat (2) nxt();
    nxt();
    chk("rd_tgt_valid", if_valid, 1);
    chk("rd_tgt_pc", if_pc, 32'h100);
    chk("rd_tgt_instr", if_instr, 32'h100 ^ K);
    // redirect coincident with the response at 0x8
    do_reset(1'b1);
    repeat (8) nxt();
    nxt();
    redir = 1'b1; redir_tgt = 32'h100;
    #1 chk("rdv_next_pc", next_pc, 32'h100);
    nxt();
    redir = 1'b0;
    #1;
    chk("rdv_dropped", if_valid, 0);
    chk("rdv_req", imem_req, 1);
    chk("rdv_addr", imem_addr, 32'h100);
    repeat (2) nxt();
    nxt();
    chk("rdv_tgt_valid", if_valid, 1);
    chk("rdv_tgt_pc", if_pc, 32'h100);
    // misaligned redirect is a sticky error
    lat = 0;
    do_reset(1'b1);
    repeat (2) nxt();
    nxt();
    redir = 1'b1; redir_tgt = 32'h102;
    #1 chk("mis_next_pc", next_pc, 8);
    nxt();
    redir = 1'b0;
    #1;
    chk("mis_err", fetch_err, 1);
    chk("mis_req", imem_req, 0);
    chk("mis_valid", if_valid, 0);
    chk("mis_pc", pc, 8);
    for (int c = 0; c < 3; c++) begin
      nxt();
      redir = 1'b1; redir_tgt = 32'h200;
      #1;
      chk("err_sticky", fetch_err, 1);
      chk("err_next_pc", next_pc, 8);
      chk("err_pc", pc, 8);
    end
    redir = 1'b0;
    do_reset(1'b1);
    // silent memory trips the timeout four cycles into REQ
    mem_en = 1'b0;
    do_reset(1'b1);
    for (int c = 1; c <= 4; c++) begin
      nxt();
      chk("to_wait_err", fetch_err, 0);
      chk("to_wait_req", imem_req, 1);
    end
    nxt();
    chk("to_err", fetch_err, 1);
    chk("to_req", imem_req, 0);
    mem_en = 1'b1;
    do_reset(1'b1);
    // reset pulse in the middle of streaming
    repeat (3) nxt();
    chk("mid_valid", if_valid, 1);
    chk("mid_if_pc", if_pc, 4);
    do_reset(1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
